// File: rtl/ball_controller.sv
// Frame-rate sequencer for the pong ball: steps the ball once per frame_tick,
// resolves wall bounces, paddle hits and misses, and sequences serve/hold/game-over.
module ball_controller #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int SPEED_X     = 2,
    parameter int SPEED_Y     = 2,
    parameter int PADDLE_X_L  = 16,
    parameter int PADDLE_X_R  = 616,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 7
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] left_paddle_y,
    input  logic [9:0] right_paddle_y,
    output logic [9:0] ball_X_location,
    output logic [9:0] ball_Y_location,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       paddle_hit,
    output logic       point_scored,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE      = 2'd1,
        ST_HOLD      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [9:0]    L_CX        = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]    L_CY        = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [9:0]    L_Y_BOTTOM  = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]    L_X_RSTOP   = 10'(PADDLE_X_R - BALL_SIZE);
    localparam logic [9:0]    L_X_LSTOP   = 10'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0]   L_SW        = 11'(SCREEN_W);
    localparam logic [10:0]   L_SH        = 11'(SCREEN_H);
    localparam logic [10:0]   L_BS        = 11'(BALL_SIZE);
    localparam logic [10:0]   L_SX        = 11'(SPEED_X);
    localparam logic [10:0]   L_SY        = 11'(SPEED_Y);
    localparam logic [10:0]   L_PXR       = 11'(PADDLE_X_R);
    localparam logic [10:0]   L_LF        = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0]   L_PH        = 11'(PADDLE_H);
    localparam logic [3:0]    L_WIN       = 4'(WIN_SCORE);
    localparam logic [HW-1:0] L_HOLD_LAST = HW'(HOLD_FRAMES - 1);

    state_t        r_state;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          r_dir_x;      // 1 = right
    logic          r_dir_y;      // 1 = down
    logic [3:0]    r_score_l;
    logic [3:0]    r_score_r;
    logic [HW-1:0] r_hold_cnt;
    logic          r_paddle_hit;
    logic          r_point_scored;
    logic          r_game_over;

    state_t        w_state_nxt;
    logic [9:0]    w_x_nxt;
    logic [9:0]    w_y_nxt;
    logic          w_dir_x_nxt;
    logic          w_dir_y_nxt;
    logic [3:0]    w_score_l_nxt;
    logic [3:0]    w_score_r_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_hit_nxt;
    logic          w_pt_nxt;
    logic          w_go_nxt;
    logic          w_miss;
    logic [9:0]    w_y_step;
    logic          w_dir_y_step;

    // All geometry is compared at 11 bits so x+speed+size never wraps.
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_lp11;
    logic [10:0] w_rp11;
    logic        w_ovl_l;
    logic        w_ovl_r;
    logic        w_hit_r;
    logic        w_miss_r;
    logic        w_hit_l;
    logic        w_miss_l;
    logic        w_hit_bottom;
    logic        w_hit_top;

    assign w_x11  = {1'b0, r_x};
    assign w_y11  = {1'b0, r_y};
    assign w_lp11 = {1'b0, left_paddle_y};
    assign w_rp11 = {1'b0, right_paddle_y};

    assign w_ovl_l      = (w_y11 + L_BS > w_lp11) && (w_y11 < w_lp11 + L_PH);
    assign w_ovl_r      = (w_y11 + L_BS > w_rp11) && (w_y11 < w_rp11 + L_PH);
    assign w_hit_r      = (w_x11 + L_SX + L_BS >= L_PXR) && (w_x11 + L_BS <= L_PXR) && w_ovl_r;
    assign w_miss_r     = (w_x11 + L_SX + L_BS >= L_SW);
    assign w_hit_l      = (w_x11 >= L_LF) && (w_x11 <= L_LF + L_SX) && w_ovl_l;
    assign w_miss_l     = (w_x11 <= L_SX);
    assign w_hit_bottom = (w_y11 + L_SY + L_BS >= L_SH);
    assign w_hit_top    = (w_y11 <= L_SY);

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_dir_x_nxt   = r_dir_x;
        w_dir_y_nxt   = r_dir_y;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        w_hold_nxt    = r_hold_cnt;
        w_hit_nxt     = 1'b0;
        w_pt_nxt      = 1'b0;
        w_miss        = 1'b0;
        w_y_step      = r_y;
        w_dir_y_step  = r_dir_y;

        if (r_dir_y) begin
            if (w_hit_bottom) begin
                w_y_step     = L_Y_BOTTOM;
                w_dir_y_step = 1'b0;
            end else begin
                w_y_step = 10'(w_y11 + L_SY);
            end
        end else begin
            if (w_hit_top) begin
                w_y_step     = 10'd0;
                w_dir_y_step = 1'b1;
            end else begin
                w_y_step = 10'(w_y11 - L_SY);
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_x_nxt = L_CX;
                w_y_nxt = L_CY;
                if (serve) w_state_nxt = ST_MOVE;
            end
            ST_MOVE: begin
                if (frame_tick) begin
                    if (r_dir_x) begin
                        if (w_hit_r) begin
                            w_x_nxt     = L_X_RSTOP;
                            w_dir_x_nxt = 1'b0;
                            w_hit_nxt   = 1'b1;
                        end else if (w_miss_r) begin
                            w_miss        = 1'b1;
                            w_score_l_nxt = r_score_l + 4'd1;
                        end else begin
                            w_x_nxt = 10'(w_x11 + L_SX);
                        end
                    end else begin
                        if (w_hit_l) begin
                            w_x_nxt     = L_X_LSTOP;
                            w_dir_x_nxt = 1'b1;
                            w_hit_nxt   = 1'b1;
                        end else if (w_miss_l) begin
                            w_miss        = 1'b1;
                            w_score_r_nxt = r_score_r + 4'd1;
                        end else begin
                            w_x_nxt = 10'(w_x11 - L_SX);
                        end
                    end
                    // A miss recentres the ball and keeps both directions, so the
                    // next serve heads toward the player who conceded.
                    if (w_miss) begin
                        w_pt_nxt   = 1'b1;
                        w_x_nxt    = L_CX;
                        w_y_nxt    = L_CY;
                        w_hold_nxt = '0;
                        if (w_score_l_nxt == L_WIN || w_score_r_nxt == L_WIN)
                            w_state_nxt = ST_GAME_OVER;
                        else
                            w_state_nxt = ST_HOLD;
                    end else begin
                        w_y_nxt     = w_y_step;
                        w_dir_y_nxt = w_dir_y_step;
                    end
                end
            end
            ST_HOLD: begin
                w_x_nxt = L_CX;
                w_y_nxt = L_CY;
                if (frame_tick) begin
                    if (r_hold_cnt == L_HOLD_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HW'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                w_x_nxt = L_CX;
                w_y_nxt = L_CY;
                if (serve) begin
                    w_state_nxt   = ST_IDLE;
                    w_score_l_nxt = 4'd0;
                    w_score_r_nxt = 4'd0;
                    w_dir_x_nxt   = 1'b1;
                    w_dir_y_nxt   = 1'b1;
                end
            end
        endcase

        w_go_nxt = (w_state_nxt == ST_GAME_OVER);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_x            <= L_CX;
            r_y            <= L_CY;
            r_dir_x        <= 1'b1;
            r_dir_y        <= 1'b1;
            r_score_l      <= 4'd0;
            r_score_r      <= 4'd0;
            r_hold_cnt     <= '0;
            r_paddle_hit   <= 1'b0;
            r_point_scored <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_dir_x        <= w_dir_x_nxt;
            r_dir_y        <= w_dir_y_nxt;
            r_score_l      <= w_score_l_nxt;
            r_score_r      <= w_score_r_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_paddle_hit   <= w_hit_nxt;
            r_point_scored <= w_pt_nxt;
            r_game_over    <= w_go_nxt;
        end
    end

    assign ball_X_location = r_x;
    assign ball_Y_location = r_y;
    assign score_left      = r_score_l;
    assign score_right     = r_score_r;
    assign paddle_hit      = r_paddle_hit;
    assign point_scored    = r_point_scored;
    assign game_over       = r_game_over;
    assign state           = r_state;

endmodule

// File: tb/tb_ball_controller.sv
// Scoreboard bench for ball_controller: directed stimulus pushes hand-computed
// expectations; a monitor pops and compares after every sampled tick/serve/reset.
module tb_ball_controller;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] left_paddle_y = 10'd0;
    logic [9:0] right_paddle_y = 10'd0;
    logic [9:0] ball_X_location;
    logic [9:0] ball_Y_location;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       paddle_hit;
    logic       point_scored;
    logic       game_over;
    logic [1:0] state;

    ball_controller dut (
        .pixel_clk       (pixel_clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .serve           (serve),
        .left_paddle_y   (left_paddle_y),
        .right_paddle_y  (right_paddle_y),
        .ball_X_location (ball_X_location),
        .ball_Y_location (ball_Y_location),
        .score_left      (score_left),
        .score_right     (score_right),
        .paddle_hit      (paddle_hit),
        .point_scored    (point_scored),
        .game_over       (game_over),
        .state           (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        bit    chk;
        string name;
        int    x, y, st, sl, sr;
        bit    hit, pt, go;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one response per edge that sampled frame_tick, serve or rst.
    initial begin : monitor
        bit   ev;
        bit   prev_ev;
        exp_t e;
        prev_ev = 1'b0;
        forever begin
            @(posedge pixel_clk);
            ev = frame_tick | serve | rst;
            @(negedge pixel_clk);
            if (ev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got event expected none");
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) begin
                        check({e.name, ".x"},     int'(ball_X_location), e.x);
                        check({e.name, ".y"},     int'(ball_Y_location), e.y);
                        check({e.name, ".state"}, int'(state),           e.st);
                        check({e.name, ".sl"},    int'(score_left),      e.sl);
                        check({e.name, ".sr"},    int'(score_right),     e.sr);
                        check({e.name, ".hit"},   int'(paddle_hit),      int'(e.hit));
                        check({e.name, ".pt"},    int'(point_scored),    int'(e.pt));
                        check({e.name, ".go"},    int'(game_over),       int'(e.go));
                    end
                end
            end else if (prev_ev) begin
                check("pulse_end.hit", int'(paddle_hit), 0);
                check("pulse_end.pt",  int'(point_scored), 0);
            end
            prev_ev = ev;
        end
    end

    task automatic push(bit chk, string nm, int x, int y, int st, int sl, int sr,
                        bit hit, bit pt, bit go);
        exp_t e;
        e.chk = chk; e.name = nm; e.x = x; e.y = y; e.st = st;
        e.sl = sl; e.sr = sr; e.hit = hit; e.pt = pt; e.go = go;
        sb_q.push_back(e);
    endtask

    task automatic tick_exp(string nm, int x, int y, int st, int sl, int sr,
                            bit hit, bit pt, bit go);
        push(1'b1, nm, x, y, st, sl, sr, hit, pt, go);
        @(negedge pixel_clk) frame_tick = 1'b1;
        @(negedge pixel_clk) frame_tick = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) begin
            push(1'b0, "", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            @(negedge pixel_clk) frame_tick = 1'b1;
            @(negedge pixel_clk) frame_tick = 1'b0;
        end
    endtask

    task automatic serve_exp(string nm, int st, int sl, int sr, bit go, bit with_tick);
        push(1'b1, nm, 316, 236, st, sl, sr, 1'b0, 1'b0, go);
        @(negedge pixel_clk);
        serve      = 1'b1;
        frame_tick = with_tick;
        @(negedge pixel_clk);
        serve      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic reset_exp(string nm);
        push(1'b1, nm, 316, 236, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge pixel_clk) rst = 1'b1;
        @(negedge pixel_clk) rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        // Idle frames, then plain serve and first step.
        left_paddle_y  = 10'd0;
        right_paddle_y = 10'd400;
        reset_exp("reset");
        ticks(2);
        tick_exp("idle_tick", 316, 236, 0, 0, 0, 0, 0, 0);
        serve_exp("serve", 1, 0, 0, 0, 0);
        tick_exp("first_step", 318, 238, 1, 0, 0, 0, 0, 0);

        // Serve coincident with a tick, bottom wall, right and left paddle bounces.
        reset_exp("reset_b");
        serve_exp("serve_with_tick", 1, 0, 0, 0, 1);
        tick_exp("b_t1", 318, 238, 1, 0, 0, 0, 0, 0);
        ticks(115);
        tick_exp("b_t117", 550, 470, 1, 0, 0, 0, 0, 0);
        tick_exp("b_t118_floor", 552, 472, 1, 0, 0, 0, 0, 0);
        tick_exp("b_t119", 554, 470, 1, 0, 0, 0, 0, 0);
        ticks(25);
        tick_exp("b_t145", 606, 418, 1, 0, 0, 0, 0, 0);
        tick_exp("b_t146_rhit", 608, 416, 1, 0, 0, 1, 0, 0);
        tick_exp("b_t147", 606, 414, 1, 0, 0, 0, 0, 0);
        left_paddle_y = 10'd140;
        ticks(289);
        tick_exp("b_t437", 26, 166, 1, 0, 0, 0, 0, 0);
        tick_exp("b_t438_lhit", 24, 168, 1, 0, 0, 1, 0, 0);
        tick_exp("b_t439", 26, 170, 1, 0, 0, 0, 0, 0);

        // Right-side miss, hold period, serve ignored in HOLD.
        left_paddle_y  = 10'd0;
        right_paddle_y = 10'd0;
        reset_exp("reset_c");
        serve_exp("serve_c", 1, 0, 0, 0, 0);
        ticks(145);
        tick_exp("c_t146_nohit", 608, 416, 1, 0, 0, 0, 0, 0);
        ticks(10);
        tick_exp("c_t157", 630, 394, 1, 0, 0, 0, 0, 0);
        tick_exp("c_t158_miss", 316, 236, 2, 1, 0, 0, 1, 0);
        serve_exp("serve_in_hold", 2, 1, 0, 0, 0);
        ticks(58);
        tick_exp("hold_59", 316, 236, 2, 1, 0, 0, 0, 0);
        tick_exp("hold_60", 316, 236, 0, 1, 0, 0, 0, 0);

        // Six more right-side misses reach the winning score.
        right_paddle_y = 10'd1000;
        for (int g = 2; g <= 7; g++) begin
            serve_exp("serve_d", 1, g - 1, 0, 0, 0);
            ticks(157);
            if (g < 7) begin
                tick_exp("d_miss", 316, 236, 2, g, 0, 0, 1, 0);
                ticks(59);
                tick_exp("d_hold_end", 316, 236, 0, g, 0, 0, 0, 0);
            end else begin
                tick_exp("d_win", 316, 236, 3, 7, 0, 0, 1, 1);
            end
        end
        ticks(2);
        tick_exp("go_tick_ignored", 316, 236, 3, 7, 0, 0, 0, 1);
        serve_exp("serve_from_go", 0, 0, 0, 0, 0);

        // Left-side miss after a right bounce; next serve keeps heading left.
        left_paddle_y  = 10'd1000;
        right_paddle_y = 10'd400;
        serve_exp("serve_e", 1, 0, 0, 0, 0);
        tick_exp("e_t1", 318, 238, 1, 0, 0, 0, 0, 0);
        ticks(144);
        tick_exp("e_t146_rhit", 608, 416, 1, 0, 0, 1, 0, 0);
        ticks(302);
        tick_exp("e_t449", 2, 190, 1, 0, 0, 0, 0, 0);
        tick_exp("e_t450_lmiss", 316, 236, 2, 0, 1, 0, 1, 0);
        ticks(59);
        tick_exp("e_hold_end", 316, 236, 0, 0, 1, 0, 0, 0);
        serve_exp("serve_e2", 1, 0, 1, 0, 0);
        tick_exp("e2_t1_left", 314, 238, 1, 0, 1, 0, 0, 0);
        ticks(3);
        tick_exp("e2_t5", 306, 246, 1, 0, 1, 0, 0, 0);

        // Reset in the middle of a rally.
        reset_exp("reset_mid_move");

        repeat (4) @(negedge pixel_clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
